dsp_mac_sequencer: RTL and testbench

//  Sequences one DSP48A1 slice as a multiply-accumulate engine: dot product of cfg_len signed 18x18 pairs.

---
 rtl/dsp_mac_sequencer.sv | 142 ++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
//   Drives one DSP48A1 slice as a signed 18x18 multiply-accumulate engine.
//   It computes the dot product of cfg_len operand pairs and returns the
//   48-bit sum.
//
//   The slice is assumed to have its A1/B1, M, OPMODE, C and P registers
//   enabled. The A0/B0 registers are bypassed.
//
//   Ports:
//     clk, rst              clock; asynchronous active-high reset
//     start, cfg_len, busy  vector start (sampled only in IDLE), length, busy flag
//     in_valid/in_ready     operand handshake, carrying in_a and in_b
//     dsp_*                 slice controls and data, and the slice P input
//     res_valid/res_ready   result handshake; res_data mirrors dsp_p
//
//   Optional feature (macro DSP_SEQ_ROUND_EN):
//     The first beat loads Z=C with C = 2**(RND_SHIFT-1).
//     This adds a rounding constant to the sum.
module dsp_mac_sequencer #(
    parameter int LEN_W     = 10,
    parameter int RND_SHIFT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      in_a,
    input  logic [17:0]      in_b,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [47:0]      dsp_c,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_cea,
    output logic             dsp_ceb,
    output logic             dsp_cem,
    output logic             dsp_ceopmode,
    output logic             dsp_cec,
    output logic             dsp_cep,
    input  logic [47:0]      dsp_p,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data
);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

    localparam logic [47:0] RND_C = 48'd1 << (RND_SHIFT - 1);
`ifdef DSP_SEQ_ROUND_EN
    localparam logic [7:0] OPM_FIRST = 8'h0D;  // X=M, Z=C
`else
    localparam logic [7:0] OPM_FIRST = 8'h01;  // X=M, Z=0
`endif
    localparam logic [7:0] OPM_ACC = 8'h09;    // X=M, Z=P

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   beats_q, beats_d;
    logic               first_q, first_d;
    // Tag pipe: stage1 is seen by OPMODE, stage2 is seen by CEP.
    logic               t1_vld_q, t1_first_q, t2_vld_q;
    logic               en_q;
    logic               accept;
    logic               start_ok;

    assign accept   = in_valid & in_ready;
    assign start_ok = (state_q == IDLE) && start && (cfg_len != '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beats_q    <= '0;
            first_q    <= 1'b0;
            t1_vld_q   <= 1'b0;
            t1_first_q <= 1'b0;
            t2_vld_q   <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            beats_q    <= beats_d;
            first_q    <= first_d;
            t1_vld_q   <= accept;
            t1_first_q <= first_q;
            t2_vld_q   <= t1_vld_q;
            en_q       <= 1'b1;
        end
    end

    // Next-state logic and counter/flag updates
    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        first_d = first_q;
        if (start_ok) begin
            beats_d = cfg_len;
            first_d = 1'b1;
        end else if (accept) begin
            beats_d = beats_q - LEN_W'(1);
            first_d = 1'b0;
        end
        case (state_q)
            IDLE:  if (start_ok) state_d = ACC;
            ACC:   if (accept && beats_q == LEN_W'(1)) state_d = DRAIN;
            // When stage1 is empty, only stage2 can still be in flight.
            // That beat lands in P on this edge, so P is final in DONE.
            DRAIN: if (!t1_vld_q) state_d = DONE;
            DONE:  if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy         = (state_q != IDLE);
        in_ready     = (state_q == ACC) && (beats_q != '0);
        res_valid    = (state_q == DONE);
        res_data     = dsp_p;
        dsp_a        = accept ? in_a : 18'd0;
        dsp_b        = accept ? in_b : 18'd0;
        dsp_cea      = accept;
        dsp_ceb      = accept;
        dsp_cem      = en_q;
        dsp_ceopmode = en_q;
        dsp_cep      = t2_vld_q;
        dsp_opmode   = 8'h00;
        if (t1_vld_q) dsp_opmode = t1_first_q ? OPM_FIRST : OPM_ACC;
`ifdef DSP_SEQ_ROUND_EN
        dsp_cec      = en_q;
        dsp_c        = en_q ? RND_C : 48'd0;
`else
        dsp_cec      = 1'b0;
        dsp_c        = 48'd0 & RND_C;
`endif
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
module tb_dsp_mac_sequencer;
`ifdef DSP_SEQ_ROUND_EN
    localparam int     RS   = 4;
    localparam longint RADD = longint'(1) << (RS - 1);
`else
    localparam int     RS   = 8;
    localparam longint RADD = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, in_valid, res_ready;
    logic [9:0]  cfg_len;
    logic [17:0] in_a, in_b, dsp_a, dsp_b;
    logic [47:0] dsp_c, dsp_p, res_data;
    logic [7:0]  dsp_opmode;
    logic        busy, in_ready, res_valid;
    logic        dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cec, dsp_cep;

    int total = 0, bad = 0, cep_cnt = 0;
    int va[$], vb[$];

    always #5 clk = ~clk;

    dsp_mac_sequencer #(.LEN_W(10), .RND_SHIFT(RS)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c), .dsp_opmode(dsp_opmode),
        .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb), .dsp_cem(dsp_cem),
        .dsp_ceopmode(dsp_ceopmode), .dsp_cec(dsp_cec), .dsp_cep(dsp_cep),
        .dsp_p(dsp_p), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data)
    );

    // DSP48A1 slice model: A1/B1, M, OPMODE, C and P registers, with no reset.
    logic signed [17:0] a1 = '0, b1 = '0;
    logic signed [35:0] m  = '0;
    logic [7:0]         opm = '0;
    logic [47:0]        c_r = '0, p = '0, xm, zm;
    assign dsp_p = p;
    always_comb begin
        xm = (opm[1:0] == 2'b01) ? {{12{m[35]}}, m} : 48'd0;
        case (opm[3:2])
            2'b10:   zm = p;
            2'b11:   zm = c_r;
            default: zm = 48'd0;
        endcase
    end
    always @(posedge clk) begin
        if (dsp_cea)      a1  <= dsp_a;
        if (dsp_ceb)      b1  <= dsp_b;
        if (dsp_cem)      m   <= a1 * b1;
        if (dsp_ceopmode) opm <= dsp_opmode;
        if (dsp_cec)      c_r <= dsp_c;
        if (dsp_cep)      p   <= xm + zm;
    end

    always @(negedge clk) if (dsp_cep === 1'b1) cep_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Reference result: dot product plus optional rounding, wrapped to 48 bits.
    function automatic logic [63:0] ref_sum(input int len);
        longint s = RADD;
        for (int i = 0; i < len; i++) s += longint'(va[i]) * longint'(vb[i]);
        return {16'd0, s[47:0]};
    endfunction

    // gap < 0 means a random gap of 0..2 cycles before each beat.
    // When poke is set, start is pulsed during ACC and again during DONE.
    task automatic run_vec(input int len, input int gap, input int hold, input bit poke);
        int n;
        logic [63:0] exp;
        exp = ref_sum(len);
        cep_cnt = 0;
        @(negedge clk); start = 1'b1; cfg_len = 10'(len);
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < len; i++) begin
            repeat ((gap < 0) ? $urandom_range(0, 2) : gap) begin
                in_valid = 1'b0; @(negedge clk);
            end
            in_valid = 1'b1; in_a = 18'(va[i]); in_b = 18'(vb[i]);
            if (poke && i == 1) begin start = 1'b1; cfg_len = 10'd7; end
            n = 0;
            while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            chk("in_ready", {63'd0, in_ready}, 64'd1);
            @(negedge clk);
            in_valid = 1'b0; start = 1'b0;
        end
        n = 1;
        while (res_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("latency", 64'(n), 64'd3);
        chk("res_data", {16'd0, res_data}, exp);
        chk("cep_count", 64'(cep_cnt), 64'(len));
        chk("ready_in_done", {63'd0, in_ready}, 64'd0);
        for (int h = 0; h < hold; h++) begin
            if (poke) begin start = 1'b1; cfg_len = 10'd3; end
            @(negedge clk);
            chk("hold_valid", {63'd0, res_valid}, 64'd1);
            chk("hold_data", {16'd0, res_data}, exp);
            chk("hold_ready0", {63'd0, in_ready}, 64'd0);
        end
        start = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("idle_after", {62'd0, busy, res_valid}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_len = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_status", {60'd0, busy, in_ready, res_valid, dsp_cep}, 64'd0);
        chk("rst_slice", {dsp_opmode, dsp_a, dsp_b, dsp_cea, dsp_ceb, dsp_cem,
                          dsp_ceopmode, dsp_cec}, 64'd0);
        chk("rst_c", {16'd0, dsp_c}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // A start with cfg_len==0 is ignored.
        start = 1'b1; cfg_len = 10'd0;
        @(negedge clk); start = 1'b0;
        chk("len0_ignored", {63'd0, busy}, 64'd0);

        va = '{1, 2, 3, 4}; vb = '{5, 6, 7, 8};
        run_vec(4, 0, 0, 1'b0);            // basic vector: 70
        va = '{-3}; vb = '{1000};
        run_vec(1, 0, 0, 1'b0);            // sign: FFFF_FFFF_F448
        va = '{1, 2, 3, 4}; vb = '{5, 6, 7, 8};
        run_vec(4, 2, 0, 1'b0);            // bubbles
        run_vec(4, 0, 5, 1'b1);            // backpressure plus ignored starts
        va = '{-1, -1}; vb = '{2, 2};
        run_vec(2, 0, 0, 1'b0);            // back-to-back: -4

        // Reset asserted after 2 of 4 beats.
        va = '{1, 2, 3, 4}; vb = '{5, 6, 7, 8};
        @(negedge clk); start = 1'b1; cfg_len = 10'd4;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_a = 18'(va[i]); in_b = 18'(vb[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("cep_before_rst", {63'd0, dsp_cep}, 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst", {60'd0, busy, in_ready, res_valid, dsp_cep}, 64'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        va = '{5}; vb = '{5};
        run_vec(1, 0, 0, 1'b0);            // 25, with no stale P

`ifdef DSP_SEQ_ROUND_EN
        va = '{1}; vb = '{1};
        run_vec(1, 0, 0, 1'b0);            // 1 + 8 = 9
`endif

        for (int t = 0; t < 8; t++) begin
            int len;
            len = $urandom_range(1, 8);
            va.delete(); vb.delete();
            for (int i = 0; i < len; i++) begin
                va.push_back(int'($urandom_range(0, 262143)) - ((t % 2) ? 131072 : 0));
                vb.push_back(int'($urandom_range(0, 262143)) - 131072);
            end
            // Fold the values into the signed 18-bit range.
            for (int i = 0; i < len; i++) begin
                if (va[i] > 131071) va[i] -= 262144;
            end
            run_vec(len, -1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
